// File: rtl/fixed_to_float_stream.sv
// Three-stage fixed-point to float converter with valid/ready flow control.
// S1 sign/magnitude, S2 normalise, S3 round-to-nearest-even and pack with status flags.
module fixed_to_float_stream #(
  parameter int FIXED_WIDTH = 16,
  parameter int FRAC_BITS   = 0,
  parameter int EXP_WIDTH   = 8,
  parameter int MANT_WIDTH  = 23
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [FIXED_WIDTH-1:0]         in_data,
  input  logic                           in_signed,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [EXP_WIDTH+MANT_WIDTH:0]  out_data,
  output logic                           out_inexact,
  output logic                           out_overflow,
  output logic                           out_underflow,
  output logic                           out_valid,
  input  logic                           out_ready
);

  localparam int PW   = (FIXED_WIDTH > 1) ? $clog2(FIXED_WIDTH) : 1;
  localparam int EW   = $clog2(FIXED_WIDTH) + 2;
  localparam int BW   = EW + EXP_WIDTH + 2;
  localparam int XW   = FIXED_WIDTH + MANT_WIDTH + 1;
  localparam int OW   = 1 + EXP_WIDTH + MANT_WIDTH;
  localparam int MW1  = MANT_WIDTH + 1;
  localparam int BIAS = 2**(EXP_WIDTH-1) - 1;
  localparam logic [BW-1:0] BIAS_V = BW'(BIAS);
  localparam logic [BW-1:0] MAXE_V = BW'(2**EXP_WIDTH - 1);

  logic w_stall;

  // S1 registers
  logic                   r_s1_valid;
  logic                   r_s1_sign;
  logic [FIXED_WIDTH-1:0] r_s1_mag;
  // S2 registers
  logic                   r_s2_valid;
  logic                   r_s2_sign;
  logic                   r_s2_zero;
  logic [FIXED_WIDTH-1:0] r_s2_norm;
  logic [EW-1:0]          r_s2_exp;
  // S3 (output) registers
  logic                   r_out_valid;
  logic [OW-1:0]          r_out_data;
  logic                   r_out_inexact;
  logic                   r_out_overflow;
  logic                   r_out_underflow;

  assign w_stall  = r_out_valid & ~out_ready;
  assign in_ready = ~w_stall;

  // ---------------- S1: sign / magnitude ----------------
  logic                   w_s1_sign;
  logic [FIXED_WIDTH-1:0] w_s1_mag;

  assign w_s1_sign = in_signed & in_data[FIXED_WIDTH-1];
  assign w_s1_mag  = w_s1_sign ? (~in_data + FIXED_WIDTH'(1)) : in_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_mag   <= '0;
    end else if (!w_stall) begin
      r_s1_valid <= in_valid;
      r_s1_sign  <= w_s1_sign;
      r_s1_mag   <= w_s1_mag;
    end
  end

  // ---------------- S2: normalise ----------------
  logic [PW-1:0]          w_p;
  logic [PW-1:0]          w_shamt;
  logic [FIXED_WIDTH-1:0] w_norm;
  logic [EW-1:0]          w_exp;

  always_comb begin
    w_p = '0;
    for (int i = 0; i < FIXED_WIDTH; i++) begin
      if (r_s1_mag[i]) w_p = PW'(i);
    end
  end

  assign w_shamt = PW'(FIXED_WIDTH-1) - w_p;
  assign w_norm  = r_s1_mag << w_shamt;
  assign w_exp   = EW'(w_p) - EW'(FRAC_BITS);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_sign  <= 1'b0;
      r_s2_zero  <= 1'b0;
      r_s2_norm  <= '0;
      r_s2_exp   <= '0;
    end else if (!w_stall) begin
      r_s2_valid <= r_s1_valid;
      r_s2_sign  <= r_s1_sign;
      r_s2_zero  <= ~|r_s1_mag;
      r_s2_norm  <= w_norm;
      r_s2_exp   <= w_exp;
    end
  end

  // ---------------- S3: round / pack ----------------
  // Bits below the leading one, zero-padded so guard and sticky always exist.
  logic [XW-1:0]         w_ext;
  logic [MANT_WIDTH-1:0] w_kept;
  logic                  w_guard;
  logic                  w_sticky;
  logic                  w_round;
  logic [MANT_WIDTH:0]   w_mant_sum;
  logic                  w_carry;
  logic [BW-1:0]         w_biased;
  logic                  w_unf;
  logic                  w_ovf;
  logic [OW-1:0]         w_res;
  logic                  w_res_inexact;
  logic                  w_res_overflow;
  logic                  w_res_underflow;

  assign w_ext      = {r_s2_norm[FIXED_WIDTH-2:0], {(MANT_WIDTH+2){1'b0}}};
  assign w_kept     = w_ext[XW-1 -: MANT_WIDTH];
  assign w_guard    = w_ext[XW-1-MANT_WIDTH];
  assign w_sticky   = |w_ext[XW-2-MANT_WIDTH:0];
  assign w_round    = w_guard & (w_sticky | w_kept[0]);
  assign w_mant_sum = {1'b0, w_kept} + MW1'(w_round);
  assign w_carry    = w_mant_sum[MANT_WIDTH];
  assign w_biased   = {{(BW-EW){r_s2_exp[EW-1]}}, r_s2_exp} + BIAS_V + BW'(w_carry);
  assign w_unf      = w_biased[BW-1] | (w_biased == '0);
  assign w_ovf      = ~w_biased[BW-1] & (w_biased >= MAXE_V);

  always_comb begin
    w_res           = {r_s2_sign, w_biased[EXP_WIDTH-1:0], w_mant_sum[MANT_WIDTH-1:0]};
    w_res_inexact   = w_guard | w_sticky;
    w_res_overflow  = 1'b0;
    w_res_underflow = 1'b0;
    if (r_s2_zero) begin
      w_res         = '0;
      w_res_inexact = 1'b0;
    end else if (w_ovf) begin
      w_res          = {r_s2_sign, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
      w_res_inexact  = 1'b1;
      w_res_overflow = 1'b1;
    end else if (w_unf) begin
      w_res           = {r_s2_sign, {(EXP_WIDTH+MANT_WIDTH){1'b0}}};
      w_res_inexact   = 1'b1;
      w_res_underflow = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid     <= 1'b0;
      r_out_data      <= '0;
      r_out_inexact   <= 1'b0;
      r_out_overflow  <= 1'b0;
      r_out_underflow <= 1'b0;
    end else if (!w_stall) begin
      r_out_valid     <= r_s2_valid;
      r_out_data      <= w_res;
      r_out_inexact   <= w_res_inexact;
      r_out_overflow  <= w_res_overflow;
      r_out_underflow <= w_res_underflow;
    end
  end

  assign out_valid     = r_out_valid;
  assign out_data      = r_out_data;
  assign out_inexact   = r_out_inexact;
  assign out_overflow  = r_out_overflow;
  assign out_underflow = r_out_underflow;

endmodule

// File: tb/tb_fixed_to_float_stream.sv
// Scoreboard bench for fixed_to_float_stream across five parameter sets.
// Only one instance is active at a time, so a single expected-result queue serves all.
module tb_fixed_to_float_stream;

  typedef struct packed {
    logic [31:0] d;
    logic [2:0]  f;   // {inexact, overflow, underflow}
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_d = '0;
  logic        in_signed = 1'b0;
  logic [4:0]  in_valid_v = '0;
  logic        out_ready = 1'b1;

  logic [4:0]  in_ready_v, out_valid_v, inx_v, ovf_v, unf_v;
  logic [31:0] out32_0, out32_1, out32_2;
  logic [15:0] out16_3, out16_4;
  logic [4:0][31:0] out_d;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  logic [4:0]       prev_stall = '0;
  logic [4:0][31:0] held = '0;

  logic [31:0] bp_exp [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                              32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};

  assign out_d = {{16'h0, out16_4}, {16'h0, out16_3}, out32_2, out32_1, out32_0};

  always #5 clk = ~clk;

  fixed_to_float_stream #(.FIXED_WIDTH(16), .FRAC_BITS(0), .EXP_WIDTH(8), .MANT_WIDTH(23)) u_d0 (
    .clk(clk), .rst(rst), .in_data(in_d[15:0]), .in_signed(in_signed), .in_valid(in_valid_v[0]),
    .in_ready(in_ready_v[0]), .out_data(out32_0), .out_inexact(inx_v[0]), .out_overflow(ovf_v[0]),
    .out_underflow(unf_v[0]), .out_valid(out_valid_v[0]), .out_ready(out_ready));

  fixed_to_float_stream #(.FIXED_WIDTH(16), .FRAC_BITS(8), .EXP_WIDTH(8), .MANT_WIDTH(23)) u_d1 (
    .clk(clk), .rst(rst), .in_data(in_d[15:0]), .in_signed(in_signed), .in_valid(in_valid_v[1]),
    .in_ready(in_ready_v[1]), .out_data(out32_1), .out_inexact(inx_v[1]), .out_overflow(ovf_v[1]),
    .out_underflow(unf_v[1]), .out_valid(out_valid_v[1]), .out_ready(out_ready));

  fixed_to_float_stream #(.FIXED_WIDTH(32), .FRAC_BITS(0), .EXP_WIDTH(8), .MANT_WIDTH(23)) u_d2 (
    .clk(clk), .rst(rst), .in_data(in_d), .in_signed(in_signed), .in_valid(in_valid_v[2]),
    .in_ready(in_ready_v[2]), .out_data(out32_2), .out_inexact(inx_v[2]), .out_overflow(ovf_v[2]),
    .out_underflow(unf_v[2]), .out_valid(out_valid_v[2]), .out_ready(out_ready));

  fixed_to_float_stream #(.FIXED_WIDTH(32), .FRAC_BITS(0), .EXP_WIDTH(5), .MANT_WIDTH(10)) u_d3 (
    .clk(clk), .rst(rst), .in_data(in_d), .in_signed(in_signed), .in_valid(in_valid_v[3]),
    .in_ready(in_ready_v[3]), .out_data(out16_3), .out_inexact(inx_v[3]), .out_overflow(ovf_v[3]),
    .out_underflow(unf_v[3]), .out_valid(out_valid_v[3]), .out_ready(out_ready));

  fixed_to_float_stream #(.FIXED_WIDTH(32), .FRAC_BITS(31), .EXP_WIDTH(5), .MANT_WIDTH(10)) u_d4 (
    .clk(clk), .rst(rst), .in_data(in_d), .in_signed(in_signed), .in_valid(in_valid_v[4]),
    .in_ready(in_ready_v[4]), .out_data(out16_4), .out_inexact(inx_v[4]), .out_overflow(ovf_v[4]),
    .out_underflow(unf_v[4]), .out_valid(out_valid_v[4]), .out_ready(out_ready));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = '0;
      end else begin
        for (int k = 0; k < 5; k++) begin
          if (prev_stall[k]) chk($sformatf("dut%0d_hold", k), 64'(out_d[k]), 64'(held[k]));
          if (out_valid_v[k] && !out_ready) begin
            chk($sformatf("dut%0d_in_ready_stall", k), 64'(in_ready_v[k]), 64'(0));
            prev_stall[k] = 1'b1;
            held[k] = out_d[k];
          end else begin
            prev_stall[k] = 1'b0;
          end
          if (out_valid_v[k] && out_ready) begin
            if (q.size() == 0) begin
              chk($sformatf("dut%0d_unexpected", k), 64'(out_d[k]), 64'hDEAD_0000_0000_0000);
            end else begin
              e = q.pop_front();
              chk($sformatf("dut%0d_result", k), {29'h0, out_d[k], inx_v[k], ovf_v[k], unf_v[k]},
                  {29'h0, e.d, e.f});
            end
          end
        end
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the transfer edge.
  task automatic send(input int k, input logic [31:0] d, input logic s,
                      input logic [31:0] ed, input logic [2:0] ef);
    int waits;
    in_d = d;
    in_signed = s;
    in_valid_v = 5'(1 << k);
    waits = 0;
    forever begin
      @(negedge clk);
      if (in_ready_v[k]) break;
      waits++;
      if (waits > 50) break;
    end
    if (waits > 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout dut%0d: in_ready stuck at %b, expected 1", k, in_ready_v[k]);
    end else begin
      q.push_back('{d: ed, f: ef});
    end
    @(posedge clk);
    #1;
    in_valid_v = '0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    chk("drain_pending", 64'(q.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time %0t, expected finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      monitor();
    join_none
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid_v), 64'(0));
    chk("rst_in_ready", 64'(in_ready_v), 64'h1F);
    chk("rst_out_data0", 64'(out_d[0]), 64'(0));
    chk("rst_out_data3", 64'(out_d[3]), 64'(0));
    chk("rst_flags", 64'({inx_v, ovf_v, unf_v}), 64'(0));
    @(posedge clk);
    #1;

    // Default parameters
    send(0, 32'h0001, 1'b1, 32'h3F800000, 3'b000);
    send(0, 32'hFFFF, 1'b1, 32'hBF800000, 3'b000);
    send(0, 32'h8000, 1'b1, 32'hC7000000, 3'b000);
    send(0, 32'h0000, 1'b1, 32'h00000000, 3'b000);
    send(0, 32'h0000, 1'b0, 32'h00000000, 3'b000);
    send(0, 32'hFFFF, 1'b0, 32'h477FFF00, 3'b000);
    send(0, 32'hFFFE, 1'b1, 32'hC0000000, 3'b000);
    drain();

    // FRAC_BITS = 8
    send(1, 32'h0180, 1'b0, 32'h3FC00000, 3'b000);
    send(1, 32'h0001, 1'b0, 32'h3B800000, 3'b000);
    send(1, 32'hFF80, 1'b1, 32'hBF000000, 3'b000);
    drain();

    // 32-bit unsigned rounding
    send(2, 32'h01000001, 1'b0, 32'h4B800000, 3'b100);
    send(2, 32'h01000003, 1'b0, 32'h4B800002, 3'b100);
    send(2, 32'hFFFFFFFF, 1'b0, 32'h4F800000, 3'b100);
    send(2, 32'h00800000, 1'b0, 32'h4B000000, 3'b000);
    send(2, 32'h01000002, 1'b0, 32'h4B800001, 3'b000);
    send(2, 32'h01000005, 1'b0, 32'h4B800002, 3'b100);
    send(2, 32'h02000003, 1'b0, 32'h4C000001, 3'b100);
    drain();

    // Half-precision style: overflow
    send(3, 32'h00010000, 1'b0, 32'h00007C00, 3'b110);
    send(3, 32'h00008000, 1'b0, 32'h00007800, 3'b000);
    send(3, 32'h0000FFFF, 1'b0, 32'h00007C00, 3'b110);
    drain();

    // Half-precision style, FRAC_BITS = 31: underflow
    send(4, 32'h00000001, 1'b0, 32'h00000000, 3'b101);
    send(4, 32'hFFFFFFFF, 1'b1, 32'h00008000, 3'b101);
    send(4, 32'h00020000, 1'b0, 32'h00000400, 3'b000);
    send(4, 32'h00010000, 1'b0, 32'h00000000, 3'b101);
    drain();

    // Backpressure: 8 back-to-back samples with out_ready low for a window
    fork
      begin
        for (int i = 0; i < 8; i++) send(0, 32'(i + 1), 1'b0, bp_exp[i], 3'b000);
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three samples in flight
    out_ready = 1'b0;
    send(0, 32'h0002, 1'b0, 32'h40000000, 3'b000);
    send(0, 32'h0003, 1'b0, 32'h40400000, 3'b000);
    send(0, 32'h0004, 1'b0, 32'h40800000, 3'b000);
    rst = 1'b1;
    q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid_v[0]), 64'(0));
    chk("midrst_in_ready", 64'(in_ready_v[0]), 64'(1));
    @(posedge clk);
    #1 out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    send(0, 32'h0007, 1'b0, 32'h40E00000, 3'b000);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
